// File: rtl/vlog_pkg.sv
// Shared definitions for the ASCII test-vector log writer.
// Build option: VLOG_CRLF_EN selects a CR LF terminator instead of LF alone.
package vlog_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam logic [7:0] CH_A     = 8'h61;
   localparam logic [7:0] CH_B     = 8'h62;
   localparam logic [7:0] CH_Y     = 8'h79;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_COMMA = 8'h2C;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_GT    = 8'h3E;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_1     = 8'h31;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_NUL   = 8'h00;

`ifdef VLOG_CRLF_EN
   localparam int unsigned TERM_LEN = 2;
`else
   localparam int unsigned TERM_LEN = 1;
`endif

   // Byte offsets within "a=<a>, b=<b> => y=<y><term>" for digit width w
   function automatic int unsigned off_a_dig(int unsigned w);
      return 2 + (w - w);
   endfunction
   function automatic int unsigned off_comma(int unsigned w);
      return 2 + w;
   endfunction
   function automatic int unsigned off_b(int unsigned w);
      return 4 + w;
   endfunction
   function automatic int unsigned off_b_dig(int unsigned w);
      return 6 + w;
   endfunction
   function automatic int unsigned off_arrow(int unsigned w);
      return 6 + 2 * w;
   endfunction
   function automatic int unsigned off_y(int unsigned w);
      return 10 + 2 * w;
   endfunction
   function automatic int unsigned off_y_dig(int unsigned w);
      return 12 + 2 * w;
   endfunction
   function automatic int unsigned off_term(int unsigned w);
      return 12 + 3 * w;
   endfunction
   function automatic int unsigned line_len(int unsigned w);
      return 12 + 3 * w + TERM_LEN;
   endfunction
   function automatic int unsigned idx_width(int unsigned w);
      return $clog2(line_len(w));
   endfunction

endpackage

// File: rtl/vlog_char_sel.sv
// Combinational byte selector: byte index plus registered record -> ASCII byte.
// Build option: VLOG_CRLF_EN adds the CR before the LF terminator.
module vlog_char_sel
   import vlog_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned IDX_W = 4
)(
   input  logic [IDX_W-1:0] i_idx,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_y,
   output logic [7:0]       o_data_c
);

   localparam int unsigned P_ADIG  = off_a_dig(WIDTH);
   localparam int unsigned P_COMMA = off_comma(WIDTH);
   localparam int unsigned P_B     = off_b(WIDTH);
   localparam int unsigned P_BDIG  = off_b_dig(WIDTH);
   localparam int unsigned P_ARROW = off_arrow(WIDTH);
   localparam int unsigned P_Y     = off_y(WIDTH);
   localparam int unsigned P_YDIG  = off_y_dig(WIDTH);
   localparam int unsigned P_TERM  = off_term(WIDTH);

   // Fixed punctuation by position, digits by scanning each operand MSB first
   always_comb begin
      o_data_c = CH_NUL;
      case (i_idx)
         IDX_W'(0):           o_data_c = CH_A;
         IDX_W'(1):           o_data_c = CH_EQ;
         IDX_W'(P_COMMA):     o_data_c = CH_COMMA;
         IDX_W'(P_COMMA + 1): o_data_c = CH_SP;
         IDX_W'(P_B):         o_data_c = CH_B;
         IDX_W'(P_B + 1):     o_data_c = CH_EQ;
         IDX_W'(P_ARROW):     o_data_c = CH_SP;
         IDX_W'(P_ARROW + 1): o_data_c = CH_EQ;
         IDX_W'(P_ARROW + 2): o_data_c = CH_GT;
         IDX_W'(P_ARROW + 3): o_data_c = CH_SP;
         IDX_W'(P_Y):         o_data_c = CH_Y;
         IDX_W'(P_Y + 1):     o_data_c = CH_EQ;
`ifdef VLOG_CRLF_EN
         IDX_W'(P_TERM):      o_data_c = CH_CR;
         IDX_W'(P_TERM + 1):  o_data_c = CH_LF;
`else
         IDX_W'(P_TERM):      o_data_c = CH_LF;
`endif
         default: begin
            for (int unsigned k = 0; k < WIDTH; k++) begin
               if (i_idx == IDX_W'(P_ADIG + k))
                  o_data_c = (|(i_a & (WIDTH'(1) << (WIDTH - 1 - k)))) ? CH_1 : CH_0;
               if (i_idx == IDX_W'(P_BDIG + k))
                  o_data_c = (|(i_b & (WIDTH'(1) << (WIDTH - 1 - k)))) ? CH_1 : CH_0;
               if (i_idx == IDX_W'(P_YDIG + k))
                  o_data_c = (|(i_y & (WIDTH'(1) << (WIDTH - 1 - k)))) ? CH_1 : CH_0;
            end
         end
      endcase
   end

endmodule

// File: rtl/vector_log_writer.sv
// Serialises one (a, b, y) record per handshake as "a=<a>, b=<b> => y=<y>"
// plus terminator, one byte per cycle on a valid/ready stream.
// Build option: VLOG_CRLF_EN selects CR LF terminator (default LF only).
module vector_log_writer
   import vlog_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             busy,
   output logic [CNT_W-1:0] rec_count
);

   localparam int unsigned      LEN      = line_len(WIDTH);
   localparam int unsigned      IDX_W    = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_y;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic             r_busy;
   logic [CNT_W-1:0] r_rec_count;

   logic [IDX_W-1:0] w_idx_nxt;
   logic [IDX_W-1:0] w_sel_idx;
   logic [7:0]       w_char_nxt;

   // out_data is registered, so look up the byte for the index about to be shown
   assign w_idx_nxt = r_idx + IDX_W'(1);
   assign w_sel_idx = (r_state == ST_EMIT) ? w_idx_nxt : '0;

   vlog_char_sel #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_char_sel (
      .i_idx    (w_sel_idx),
      .i_a      (r_a),
      .i_b      (r_b),
      .i_y      (r_y),
      .o_data_c (w_char_nxt)
   );

   // Capture / emit FSM with byte index, record registers and completed-record count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_y         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= CH_NUL;
         r_busy      <= 1'b0;
         r_rec_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a         <= in_a;
                  r_b         <= in_b;
                  r_y         <= in_y;
                  r_idx       <= '0;
                  r_state     <= ST_EMIT;
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_char_nxt;
                  r_busy      <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (r_idx == IDX_LAST) begin
                     r_state     <= ST_IDLE;
                     r_idx       <= '0;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_data  <= CH_NUL;
                     r_busy      <= 1'b0;
                     r_rec_count <= r_rec_count + CNT_W'(1);
                  end else begin
                     r_idx      <= w_idx_nxt;
                     r_out_data <= w_char_nxt;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;
   assign rec_count = r_rec_count;

endmodule

// File: tb/tb_vector_log_writer.sv
// Bench for vector_log_writer: instance 0 is WIDTH=1/CNT_W=16, instance 1 is WIDTH=4/CNT_W=2.
`timescale 1ns/1ps
module tb_vector_log_writer;

`ifdef VLOG_CRLF_EN
   localparam int TERM_N = 2;
`else
   localparam int TERM_N = 1;
`endif
   localparam int LEN0 = 13 + 3 * 1 + (TERM_N - 1);

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iv   [2];
   logic [3:0] ia   [2];
   logic [3:0] ib   [2];
   logic [3:0] iy   [2];
   logic       ordy [2];
   logic       bp_mode;

   wire        rdy0, ov0, busy0;
   wire [7:0]  od0;
   wire [15:0] rc0;
   wire        rdy1, ov1, busy1;
   wire [7:0]  od1;
   wire [1:0]  rc1;

   always #5 clk = ~clk;

   vector_log_writer #(.WIDTH(1), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy0),
      .in_a(ia[0][0:0]), .in_b(ib[0][0:0]), .in_y(iy[0][0:0]),
      .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
      .busy(busy0), .rec_count(rc0));

   vector_log_writer #(.WIDTH(4), .CNT_W(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy1),
      .in_a(ia[1]), .in_b(ib[1]), .in_y(iy[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
      .busy(busy1), .rec_count(rc1));

   int n_cmp = 0;
   int n_err = 0;
   int npop [2];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   typedef struct {
      int         inst;
      logic [3:0] a, b, y;
      logic [199:0] txt;
      int         n;
      int         rc;
   } vec_t;
   vec_t tbl [6];

   function automatic logic       f_rdy (int i); return (i == 0) ? rdy0 : rdy1; endfunction
   function automatic logic       f_ov  (int i); return (i == 0) ? ov0 : ov1; endfunction
   function automatic logic       f_busy(int i); return (i == 0) ? busy0 : busy1; endfunction
   function automatic logic [7:0] f_od  (int i); return (i == 0) ? od0 : od1; endfunction
   function automatic logic [31:0] f_rc (int i); return (i == 0) ? 32'(rc0) : 32'(rc1); endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(int i, logic [7:0] b);
      if (i == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   task automatic push_term(int i);
      if (TERM_N == 2) push(i, 8'h0D);
      push(i, 8'h0A);
   endtask

   task automatic push_txt(int i, logic [199:0] txt, int n);
      for (int k = 0; k < n; k++) push(i, txt[8 * (n - 1 - k) +: 8]);
      push_term(i);
   endtask

   function automatic string bits_str(logic [3:0] v, int w);
      string s = "";
      for (int k = w - 1; k >= 0; k--) s = {s, v[2'(k)] ? "1" : "0"};
      return s;
   endfunction

   task automatic push_str(int i, string s);
      for (int k = 0; k < s.len(); k++) push(i, 8'(s[k]));
      push_term(i);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Pops one expected byte per transfer and checks outputs hold while stalled
   task automatic monitor();
      logic       pv [2];
      logic       pr [2];
      logic [7:0] pd [2];
      logic       prst;
      pv = '{1'b0, 1'b0}; pr = '{1'b1, 1'b1}; pd = '{8'h00, 8'h00}; prst = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (prst && pv[i] && !pr[i]) begin
               chk($sformatf("stall_valid[%0d]", i), 32'(f_ov(i)), 32'd1);
               chk($sformatf("stall_data[%0d]", i), 32'(f_od(i)), 32'(pd[i]));
            end
            if (rst_n && f_ov(i) && ordy[i]) begin
               logic [7:0] e;
               int qs;
               qs = (i == 0) ? q0.size() : q1.size();
               if (qs == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL extra_byte[%0d]: got 0x%02h, expected no byte", i, f_od(i));
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("byte%0d[%0d]", npop[i], i), 32'(f_od(i)), 32'(e));
                  npop[i]++;
               end
            end
            pv[i] = f_ov(i);
            pr[i] = ordy[i];
            pd[i] = f_od(i);
         end
         prst = rst_n;
      end
   endtask

   task automatic rdy_drv();
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) ordy[i] = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic send(int i, logic [3:0] a, logic [3:0] b, logic [3:0] y);
      int t = 0;
      while (!f_rdy(i) && t < 200) begin cyc(); t++; end
      if (!f_rdy(i)) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout[%0d]: got in_ready=0, expected 1", i);
      end
      ia[i] = a; ib[i] = b; iy[i] = y; iv[i] = 1'b1;
      cyc();
      iv[i] = 1'b0;
   endtask

   task automatic drain(int i, bit scramble);
      int t = 0;
      while (((i == 0 ? q0.size() : q1.size()) != 0 || !f_rdy(i)) && t < 600) begin
         if (scramble) begin
            ia[i] = 4'($urandom); ib[i] = 4'($urandom); iy[i] = 4'($urandom);
         end
         cyc();
         t++;
      end
      if (t >= 600) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout[%0d]: got %0d bytes pending, expected 0", i,
                  (i == 0) ? q0.size() : q1.size());
      end
   endtask

   initial begin
      int base, t, nrise, last_rise, cnum;
      logic pb;
      logic [3:0] a, b, y;

      rst_n = 1'b0; bp_mode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; iy[i] = '0; ordy[i] = 1'b1; npop[i] = 0;
      end
      tbl[0] = '{0, 4'h1, 4'h0, 4'h0, 200'("a=1, b=0 => y=0"), 15, 2};
      tbl[1] = '{0, 4'h0, 4'h1, 4'h1, 200'("a=0, b=1 => y=1"), 15, 3};
      tbl[2] = '{0, 4'h1, 4'h1, 4'h1, 200'("a=1, b=1 => y=1"), 15, 4};
      tbl[3] = '{1, 4'hA, 4'h3, 4'h2, 200'("a=1010, b=0011 => y=0010"), 24, 1};
      tbl[4] = '{1, 4'hF, 4'h0, 4'h5, 200'("a=1111, b=0000 => y=0101"), 24, 2};
      tbl[5] = '{0, 4'h0, 4'h0, 4'h0, 200'("a=0, b=0 => y=0"), 15, 5};

      fork
         monitor();
         rdy_drv();
      join_none

      repeat (3) cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_in_ready[%0d]", i), 32'(f_rdy(i)), 32'd1);
         chk($sformatf("rst_out_valid[%0d]", i), 32'(f_ov(i)), 32'd0);
         chk($sformatf("rst_out_data[%0d]", i), 32'(f_od(i)), 32'h00);
         chk($sformatf("rst_busy[%0d]", i), 32'(f_busy(i)), 32'd0);
         chk($sformatf("rst_rec_count[%0d]", i), f_rc(i), 32'd0);
      end

      // Latency and full-rate throughput, WIDTH=1
      push_txt(0, 200'("a=1, b=0 => y=0"), 15);
      ia[0] = 4'h1; ib[0] = 4'h0; iy[0] = 4'h0; iv[0] = 1'b1;
      cyc();
      iv[0] = 1'b0;
      chk("first_valid", 32'(ov0), 32'd1);
      chk("first_byte", 32'(od0), 32'h61);
      chk("first_busy", 32'(busy0), 32'd1);
      chk("first_in_ready", 32'(rdy0), 32'd0);
      for (int k = 1; k < LEN0; k++) begin
         cyc();
         chk($sformatf("stream_valid%0d", k), 32'(ov0), 32'd1);
      end
      cyc();
      chk("done_in_ready", 32'(rdy0), 32'd1);
      chk("done_valid", 32'(ov0), 32'd0);
      chk("done_busy", 32'(busy0), 32'd0);
      chk("done_rec_count", 32'(rc0), 32'd1);

      // Table of records under random backpressure with inputs scrambled mid-line
      bp_mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push_txt(tbl[k].inst, tbl[k].txt, tbl[k].n);
         send(tbl[k].inst, tbl[k].a, tbl[k].b, tbl[k].y);
         drain(tbl[k].inst, 1'b1);
         chk($sformatf("tbl_rec_count%0d", k), f_rc(tbl[k].inst), 32'(tbl[k].rc));
      end

      // Reset in the middle of a line
      bp_mode = 1'b0;
      cyc();
      base = npop[0];
      push_str(0, "a=1, b=1 => y=0");
      send(0, 4'h1, 4'h1, 4'h0);
      t = 0;
      while (npop[0] < base + 7 && t < 100) begin cyc(); t++; end
      chk("midrst_reached", 32'(npop[0] - base), 32'd7);
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      q0.delete();
      chk("midrst_valid", 32'(ov0), 32'd0);
      chk("midrst_rec_count", 32'(rc0), 32'd0);
      chk("midrst_in_ready", 32'(rdy0), 32'd1);
      push_str(0, "a=0, b=1 => y=0");
      send(0, 4'h0, 4'h1, 4'h0);
      drain(0, 1'b0);
      chk("postrst_rec_count", 32'(rc0), 32'd1);

      // in_valid held high: one capture per LEN+1 cycles
      for (int k = 0; k < 3; k++) push_str(0, "a=1, b=1 => y=1");
      ia[0] = 4'h1; ib[0] = 4'h1; iy[0] = 4'h1; iv[0] = 1'b1;
      pb = busy0; nrise = 0; last_rise = 0; cnum = 0;
      while (nrise < 3 && cnum < 200) begin
         cyc();
         cnum++;
         if (busy0 && !pb) begin
            if (nrise > 0) chk($sformatf("spacing%0d", nrise), 32'(cnum - last_rise), 32'(LEN0 + 1));
            last_rise = cnum;
            nrise++;
         end
         pb = busy0;
      end
      iv[0] = 1'b0;
      chk("cont_captures", 32'(nrise), 32'd3);
      drain(0, 1'b0);
      chk("cont_rec_count", 32'(rc0), 32'd4);

      // CNT_W=2 instance: five records, counter wraps through zero
      bp_mode = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a = 4'($urandom); b = 4'($urandom); y = 4'($urandom);
         push_str(1, {"a=", bits_str(a, 4), ", b=", bits_str(b, 4), " => y=", bits_str(y, 4)});
         send(1, a, b, y);
         drain(1, 1'b1);
         chk($sformatf("wrap_rec_count%0d", k), f_rc(1), 32'((k + 1) % 4));
      end

      bp_mode = 1'b0;
      repeat (3) cyc();
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
